cdb_arbiter: RTL

- Shares the single common data bus between the functional units: 4 ALUs, the branch comparator and the load unit.
- Each unit hands its finished result (ROB tag + data) to a private holding slot through a valid/ready handshake.
- The arbiter broadcasts one slot per cycle, round-robin, on a registered CDB port. It also produces the one-hot set_rob_valid vector for the ROB.
- Sits between the reservation-station/ALU outputs and the cdb/rob blocks. It replaces the per-tag OR-enable scheme.

---
 rtl/cdb_arbiter_pkg.sv | 33 +++
 rtl/cdb_arbiter_if.sv | 26 ++
 rtl/cdb_arbiter_rr_picker.sv | 26 ++
 rtl/cdb_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing for the common-data-bus arbiter.
package cdb_arbiter_pkg;

  localparam int unsigned NUM_REQ = 6;
  localparam int unsigned NUM_FU  = NUM_REQ;
  localparam int unsigned TAG_W   = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SRC_W   = $clog2(NUM_REQ);
  localparam int unsigned ROB_N   = 1 << TAG_W;

  localparam int unsigned ALU0_IDX = 0;
  localparam int unsigned ALU1_IDX = 1;
  localparam int unsigned ALU2_IDX = 2;
  localparam int unsigned ALU3_IDX = 3;
  localparam int unsigned BR_IDX   = 4;
  localparam int unsigned LD_IDX   = 5;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_word_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // One-hot ROB entry select for a broadcast tag.
  function automatic logic [ROB_N-1:0] tag_onehot(input logic [TAG_W-1:0] tag);
    return ROB_N'(1) << tag;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result handshake from the functional units and the CDB broadcast port.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           flush;
  logic                           cdb_valid;
  logic [TAG_W-1:0]               cdb_tag;
  logic [DATA_W-1:0]              cdb_data;
  logic [SRC_W-1:0]               cdb_src;
  logic [ROB_N-1:0]               set_rob_valid;

  modport master (
    output req_valid, req_tag, req_data, flush,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, set_rob_valid
  );

  modport slave (
    input  req_valid, req_tag, req_data, flush,
    output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, set_rob_valid
  );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin find-first: first set request at or after ptr_i, wrapping.
module cdb_arbiter_rr_picker
  import cdb_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SRC_W-1:0]   ptr_i,
  output logic               grant_any_o,
  output logic [SRC_W-1:0]   grant_idx_o
);

  logic [SRC_W-1:0] idx_c;

  always_comb begin
    grant_any_o = 1'b0;
    grant_idx_o = '0;
    idx_c       = ptr_i;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_any_o && req_i[idx_c]) begin
        grant_any_o = 1'b1;
        grant_idx_o = idx_c;
      end
      idx_c = (idx_c == SRC_W'(NUM_REQ - 1)) ? '0 : idx_c + SRC_W'(1);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Per-unit result holding slots, round-robin CDB broadcast and ROB valid-set vector.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  cdb_arbiter_if.slave arb_if
);

  slot_state_e      slot_q [NUM_REQ];
  slot_state_e      slot_d [NUM_REQ];
  cdb_word_t        word_q [NUM_REQ];
  cdb_word_t        word_d [NUM_REQ];
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q,  cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q,   cdb_src_d;
  logic [ROB_N-1:0]  set_rob_q,   set_rob_d;

  logic [NUM_REQ-1:0] full_c, grant_c, ready_c, accept_c;
  logic               grant_any_c;
  logic [SRC_W-1:0]   grant_idx_c;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      full_c[i] = (slot_q[i] == SLOT_FULL);
    end
  end

  cdb_arbiter_rr_picker u_picker (
    .req_i       (full_c),
    .ptr_i       (rr_ptr_q),
    .grant_any_o (grant_any_c),
    .grant_idx_o (grant_idx_c)
  );

  // A slot being drained this cycle can take a new result in the same cycle.
  always_comb begin
    grant_c = '0;
    if (grant_any_c) begin
      grant_c[grant_idx_c] = 1'b1;
    end
    ready_c  = {NUM_REQ{!arb_if.flush}} & (~full_c | grant_c);
    accept_c = arb_if.req_valid & ready_c;
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      slot_d[i] = slot_q[i];
      word_d[i] = word_q[i];
    end
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    set_rob_d   = '0;

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_if.flush) begin
        slot_d[i] = SLOT_EMPTY;
      end else if (accept_c[i]) begin
        slot_d[i] = SLOT_FULL;
        word_d[i] = '{tag: arb_if.req_tag[i], data: arb_if.req_data[i]};
      end else if (grant_c[i]) begin
        slot_d[i] = SLOT_EMPTY;
      end
    end

    // Flush squashes the broadcast and leaves the pointer where it was.
    if (grant_any_c && !arb_if.flush) begin
      rr_ptr_d    = (grant_idx_c == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + SRC_W'(1);
      cdb_valid_d = 1'b1;
      cdb_tag_d   = word_q[grant_idx_c].tag;
      cdb_data_d  = word_q[grant_idx_c].data;
      cdb_src_d   = grant_idx_c;
      set_rob_d   = tag_onehot(word_q[grant_idx_c].tag);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= SLOT_EMPTY;
        word_q[i] <= '0;
      end
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      set_rob_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= slot_d[i];
        word_q[i] <= word_d[i];
      end
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      set_rob_q   <= set_rob_d;
    end
  end

  assign arb_if.req_ready     = ready_c;
  assign arb_if.cdb_valid     = cdb_valid_q;
  assign arb_if.cdb_tag       = cdb_tag_q;
  assign arb_if.cdb_data      = cdb_data_q;
  assign arb_if.cdb_src       = cdb_src_q;
  assign arb_if.set_rob_valid = set_rob_q;

endmodule
